// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared state encoding and default widths for the Z80 memory bridge
package z80_bus_pkg;
  localparam int ADR_W = 15;
  localparam int DAT_W = 8;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {IDLE, RD_STB, RD_CAP, WAIT, HOLD} state_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: wait-state down-counter that loads a start value and stops at zero
module wait_timer
  import z80_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !done) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/z80_mem_bridge.sv
// z80_mem_bridge: Z80 memory cycles to registered SRAM strobes with wait-state insertion
module z80_mem_bridge
  import z80_bus_pkg::*;
#(
  parameter int ADR         = ADR_W,
  parameter int DAT         = DAT_W,
  parameter bit SEL_A15     = 1'b1,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    z_a,
  input  logic [DAT-1:0] z_d_in,
  output logic [DAT-1:0] z_d_out,
  output logic           z_d_oe,
  input  logic           z_mreq_n,
  input  logic           z_rd_n,
  input  logic           z_wr_n,
  input  logic           z_rfsh_n,
  output logic           z_wait_n,
  output logic [ADR-1:0] m_a,
  output logic [DAT-1:0] m_d_out,
  input  logic [DAT-1:0] m_d_in,
  output logic           m_cs,
  output logic           m_we,
  output logic           m_oe,
  output logic           err
);
  localparam logic [CNT_W-1:0] WLOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  localparam bit NO_WAIT = WAIT_CYCLES == 0;
  state_t state, state_d;
  logic is_wr, is_wr_d;
  logic [ADR-1:0] a_d;
  logic [DAT-1:0] dout_d, zd_d;
  logic doe_d, wait_d, cs_d, we_d, oe_d, err_d;
  logic load, en, done, hit;
  assign hit = z_rfsh_n && z_a[15] == SEL_A15;
  wait_timer u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .en   (en),
    .val  (WLOAD),
    .done (done)
  );
  always_comb begin
    state_d = state;
    is_wr_d = is_wr;
    a_d = m_a;
    dout_d = m_d_out;
    zd_d = z_d_out;
    doe_d = z_d_oe;
    wait_d = 1'b1;
    cs_d = 1'b0;
    we_d = 1'b0;
    oe_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    en = 1'b0;
    case (state)
      IDLE:
        if (!z_mreq_n) begin
          if (!hit) state_d = HOLD;
          else if (!z_rd_n && !z_wr_n) begin
            state_d = HOLD;
            err_d = 1'b1;
          end else if (!z_rd_n || !z_wr_n) begin
            state_d = RD_STB;
            is_wr_d = !z_wr_n;
            a_d = z_a[ADR-1:0];
            dout_d = z_wr_n ? m_d_out : z_d_in;
            wait_d = 1'b0;
            cs_d = 1'b1;
            we_d = !z_wr_n;
            oe_d = z_wr_n;
          end
        end
      RD_STB: begin
        state_d = !is_wr ? RD_CAP : NO_WAIT ? HOLD : WAIT;
        wait_d = is_wr && NO_WAIT;
        load = is_wr && !NO_WAIT;
      end
      RD_CAP:
        if (z_mreq_n) begin
          state_d = IDLE;
          doe_d = 1'b0;
          err_d = 1'b1;
        end else begin
          state_d = NO_WAIT ? HOLD : WAIT;
          zd_d = m_d_in;
          doe_d = 1'b1;
          wait_d = NO_WAIT;
          load = !NO_WAIT;
        end
      WAIT:
        if (z_mreq_n) begin
          state_d = IDLE;
          doe_d = 1'b0;
          err_d = 1'b1;
        end else begin
          state_d = done ? HOLD : WAIT;
          wait_d = done;
          en = !done;
        end
      HOLD:
        if (z_mreq_n) begin
          state_d = IDLE;
          doe_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      is_wr <= 1'b0;
      m_a <= '0;
      m_d_out <= '0;
      z_d_out <= '0;
      z_d_oe <= 1'b0;
      z_wait_n <= 1'b1;
      m_cs <= 1'b0;
      m_we <= 1'b0;
      m_oe <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      is_wr <= is_wr_d;
      m_a <= a_d;
      m_d_out <= dout_d;
      z_d_out <= zd_d;
      z_d_oe <= doe_d;
      z_wait_n <= wait_d;
      m_cs <= cs_d;
      m_we <= we_d;
      m_oe <= oe_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_z80_mem_bridge.sv
// tb_z80_mem_bridge: directed checks of the bridge at WAIT_CYCLES 0, 1 and 15
module tb_z80_mem_bridge;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] z_a;
  logic [7:0] z_d_in;
  logic z_mreq_n, z_rd_n, z_wr_n, z_rfsh_n;
  logic [7:0] zdo [3];
  logic [7:0] mdo [3];
  logic [7:0] mdi [3];
  logic [14:0] ma [3];
  logic doe [3];
  logic wn [3];
  logic cs [3];
  logic we [3];
  logic oe [3];
  logic er [3];
  int n_chk = 0, n_fail = 0;
  int low [3], errc [3], csc [3], wec [3], oec [3], cs_first [3], doe_first [3];
  int both = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int WC = g == 0 ? 0 : g == 1 ? 1 : 15;
    logic [7:0] mem [0:32767];
    z80_mem_bridge #(.WAIT_CYCLES(WC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .z_a     (z_a),
      .z_d_in  (z_d_in),
      .z_d_out (zdo[g]),
      .z_d_oe  (doe[g]),
      .z_mreq_n(z_mreq_n),
      .z_rd_n  (z_rd_n),
      .z_wr_n  (z_wr_n),
      .z_rfsh_n(z_rfsh_n),
      .z_wait_n(wn[g]),
      .m_a     (ma[g]),
      .m_d_out (mdo[g]),
      .m_d_in  (mdi[g]),
      .m_cs    (cs[g]),
      .m_we    (we[g]),
      .m_oe    (oe[g]),
      .err     (er[g])
    );
    always @(posedge clk) begin
      if (cs[g] && we[g]) mem[ma[g]] <= mdo[g];
      if (cs[g] && oe[g]) mdi[g] <= mem[ma[g]];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic access(input logic [15:0] a, input logic rd, input logic wr, input logic rf,
                        input logic [7:0] d, input int rel);
    z_a = a;
    z_d_in = d;
    z_rd_n = rd;
    z_wr_n = wr;
    z_rfsh_n = rf;
    z_mreq_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      low[i] = 0; errc[i] = 0; csc[i] = 0; wec[i] = 0; oec[i] = 0;
      cs_first[i] = 0; doe_first[i] = 0;
    end
    for (int s = 1; s <= 24; s++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        low[i] += int'(!wn[i]);
        errc[i] += int'(er[i]);
        csc[i] += int'(cs[i]);
        wec[i] += int'(we[i]);
        oec[i] += int'(oe[i]);
        both += int'(we[i] & oe[i]);
        if (cs[i] && cs_first[i] == 0) cs_first[i] = s;
        if (doe[i] && doe_first[i] == 0) doe_first[i] = s;
      end
      if (s == rel || s == 20) begin
        z_mreq_n = 1'b1;
        z_rd_n = 1'b1;
        z_wr_n = 1'b1;
        z_rfsh_n = 1'b1;
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    z_a = '0;
    z_d_in = '0;
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    z_wr_n = 1'b1;
    z_rfsh_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {wn[1], doe[1], cs[1], we[1], oe[1], er[1]}, 6'b100000);
    check("reset_data", {zdo[1], mdo[1], 1'b0, ma[1]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    access(16'h8005, 1'b1, 1'b0, 1'b1, 8'hA5, 20);
    check("wr_we_pulses", wec[1], 1);
    check("wr_oe_pulses", oec[1], 0);
    check("wr_wait_wc1", low[1], 2);
    check("wr_wait_wc0", low[0], 1);
    check("wr_wait_wc15", low[2], 16);
    check("wr_no_err", errc[1], 0);
    check("wr_addr_data", {ma[1], mdo[1]}, {15'h0005, 8'hA5});
    access(16'h8005, 1'b0, 1'b1, 1'b1, 8'h00, 20);
    check("rd_cs_first", cs_first[1], 1);
    check("rd_cs_pulses", csc[1], 1);
    check("rd_strobes", {oec[1][3:0], wec[1][3:0]}, 8'h10);
    check("rd_doe_first", doe_first[1], 3);
    check("rd_wait_wc1", low[1], 3);
    check("rd_wait_wc0", low[0], 2);
    check("rd_wait_wc15", low[2], 17);
    check("rd_data_wc1", zdo[1], 8'hA5);
    check("rd_data_wc15", zdo[2], 8'hA5);
    check("rd_doe_after", doe[1], 0);
    access(16'hFFFF, 1'b1, 1'b0, 1'b1, 8'h3C, 20);
    check("wffff_we_pulses", wec[1], 1);
    check("wffff_addr", ma[1], 15'h7FFF);
    check("wffff_data", mdo[1], 8'h3C);
    access(16'hFFFF, 1'b0, 1'b1, 1'b1, 8'h00, 20);
    check("rffff_data_wc1", zdo[1], 8'h3C);
    check("rffff_data_wc0", zdo[0], 8'h3C);
    access(16'h1234, 1'b0, 1'b1, 1'b1, 8'h00, 20);
    check("unsel_strobes", csc[0] + csc[1] + csc[2], 0);
    check("unsel_wait", low[0] + low[1] + low[2], 0);
    access(16'h8000, 1'b1, 1'b1, 1'b0, 8'h00, 20);
    check("rfsh_strobes", csc[0] + csc[1] + csc[2], 0);
    check("rfsh_wait", low[0] + low[1] + low[2], 0);
    access(16'h8000, 1'b0, 1'b0, 1'b1, 8'h55, 20);
    check("both_err", errc[1], 1);
    check("both_strobes", csc[1], 0);
    check("both_wait", low[1], 0);
    access(16'h8005, 1'b0, 1'b1, 1'b1, 8'h00, 2);
    check("abort_err", errc[1], 1);
    check("abort_doe", doe_first[1], 0);
    check("abort_doe_end", doe[1], 0);
    z_a = 16'h8010;
    z_d_in = 8'h77;
    z_wr_n = 1'b0;
    z_mreq_n = 1'b0;
    @(negedge clk);
    check("rstw_strobe", {cs[1], we[1]}, 2'b11);
    rst_n = 1'b0;
    z_mreq_n = 1'b1;
    z_wr_n = 1'b1;
    @(negedge clk);
    check("rstw_outputs", {wn[1], doe[1], cs[1], we[1], oe[1], er[1]}, 6'b100000);
    check("rstw_data", {zdo[1], mdo[1], 1'b0, ma[1]}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    access(16'h8005, 1'b0, 1'b1, 1'b1, 8'h00, 20);
    check("post_rst_data", zdo[1], 8'hA5);
    check("post_rst_wait", low[1], 3);
    check("post_rst_err", errc[1], 0);
    check("we_oe_overlap", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
